// File: rtl/cpup_reg_pkg.sv
// cpup_reg_pkg: register codes, control-bus field bases, sequencer states and bus-field helpers
package cpup_reg_pkg;
  localparam int REG_A = 0, REG_B = 1, REG_C = 2, REG_P = 3, REG_S = 4, REG_ST = 5;
  localparam int REG_EXT = 6, REG_ILLEGAL = 7;
  localparam int LD_BASE = 0, OE_BASE = 6;
  typedef enum logic [1:0] {IDLE, DRIVE, LOAD, TURN} state_t;
  function automatic logic [11:0] oe_bits(input logic [2:0] src);
    return src <= 3'(REG_ST) ? 12'(1) << (OE_BASE + int'(src)) : 12'd0;
  endfunction
  function automatic logic [11:0] ld_bits(input logic [5:0] dst);
    return 12'(dst) << LD_BASE;
  endfunction
endpackage

// File: rtl/register_transfer_sequencer_if.sv
// register_transfer_sequencer_if: two requester channels plus register control bus and status
interface register_transfer_sequencer_if;
  logic req0_valid, req1_valid;
  logic [2:0] req0_src, req1_src;
  logic [5:0] req0_dst, req1_dst;
  logic req0_ready, req1_ready;
  logic [11:0] Register_Control_Bus;
  logic busy, done, done_id, err;
  modport master(
    output req0_valid, req1_valid, req0_src, req1_src, req0_dst, req1_dst,
    input req0_ready, req1_ready, Register_Control_Bus, busy, done, done_id, err
  );
  modport slave(
    input req0_valid, req1_valid, req0_src, req1_src, req0_dst, req1_dst,
    output req0_ready, req1_ready, Register_Control_Bus, busy, done, done_id, err
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin; pointer moves past whoever was granted when accept fires
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       ptr
);
  logic [1:0] grant_q;
  logic ptr_n;
  // an accepted ready always equals the grant issued on the previous edge
  always_comb ptr_n = accept ? grant_q[0] : ptr;
  always_comb grant = &valid ? (ptr_n ? 2'b10 : 2'b01) : valid;
  always_ff @(posedge clk) begin
    ptr <= rst ? 1'b0 : ptr_n;
    grant_q <= rst ? 2'b00 : grant;
  end
endmodule

// File: rtl/register_transfer_sequencer.sv
// register_transfer_sequencer: arbitrates two requesters and sequences DRIVE/LOAD/TURN on the register control bus
module register_transfer_sequencer
  import cpup_reg_pkg::*;
(
  input logic clock_in,
  input logic reset_in,
  register_transfer_sequencer_if.slave io
);
  state_t state, nstate;
  logic [1:0] valid, ready, hit, grant, ready_n;
  logic [2:0] src_q, a_src;
  logic [5:0] dst_q, a_dst;
  logic [11:0] bus_n;
  logic ptr, acc, illegal, busy_n, done_n, err_n;
  assign valid = {io.req1_valid, io.req0_valid};
  assign ready = {io.req1_ready, io.req0_ready};
  assign hit = valid & ready;
  assign acc = |hit;
  assign a_src = hit[1] ? io.req1_src : io.req0_src;
  assign a_dst = hit[1] ? io.req1_dst : io.req0_dst;
  assign illegal = a_src == 3'(REG_ILLEGAL) || a_dst == 6'd0;
  // ptr holds the inverse of the in-flight requester, so it doubles as the latched id
  rr_arbiter2 u_arb (
    .clk(clock_in), .rst(reset_in), .valid(valid), .accept(acc), .grant(grant), .ptr(ptr)
  );
  always_ff @(posedge clock_in) begin
    state <= reset_in ? IDLE : nstate;
    if (acc) begin
      src_q <= a_src;
      dst_q <= a_dst;
    end
  end
  always_comb
    nstate = state == IDLE ? (acc && !illegal ? DRIVE : IDLE) :
             state == DRIVE ? LOAD : state == LOAD ? TURN : IDLE;
  always_comb begin
    bus_n = nstate == DRIVE ? oe_bits(a_src) :
            nstate == LOAD ? oe_bits(src_q) | ld_bits(dst_q) : 12'd0;
    busy_n = nstate != IDLE;
    done_n = nstate == TURN;
    err_n = acc && illegal;
    ready_n = nstate == IDLE ? grant : 2'b00;
  end
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      io.Register_Control_Bus <= '0;
      io.busy <= 1'b0;
      io.done <= 1'b0;
      io.done_id <= 1'b0;
      io.err <= 1'b0;
      io.req0_ready <= 1'b0;
      io.req1_ready <= 1'b0;
    end else begin
      io.Register_Control_Bus <= bus_n;
      io.busy <= busy_n;
      io.done <= done_n;
      io.done_id <= ~ptr;
      io.err <= err_n;
      {io.req1_ready, io.req0_ready} <= ready_n;
    end
  end
endmodule

// File: tb/tb_register_transfer_sequencer.sv
// tb_register_transfer_sequencer: directed transfers, arbitration, illegal requests and mid-transfer reset
module tb_register_transfer_sequencer;
  import cpup_reg_pkg::*;
  logic clock_in = 1'b0;
  logic reset_in = 1'b1;
  bit arm = 1'b0;
  int total = 0, bad = 0;
  register_transfer_sequencer_if io();
  register_transfer_sequencer dut (.clock_in(clock_in), .reset_in(reset_in), .io(io));
  always #5 clock_in = ~clock_in;
  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask
  task automatic req(input int n, input logic v, input logic [2:0] s, input logic [5:0] d);
    if (n == 0) begin
      io.req0_valid = v; io.req0_src = s; io.req0_dst = d;
    end else begin
      io.req1_valid = v; io.req1_src = s; io.req1_dst = d;
    end
  endtask
  task automatic outs(input string tag, input logic [11:0] bus, input logic busy, input logic done,
                      input logic err, input logic [1:0] rdy);
    chk({tag, ".bus"}, io.Register_Control_Bus, bus);
    chk({tag, ".busy"}, 12'(io.busy), 12'(busy));
    chk({tag, ".done"}, 12'(io.done), 12'(done));
    chk({tag, ".err"}, 12'(io.err), 12'(err));
    chk({tag, ".ready"}, 12'({io.req1_ready, io.req0_ready}), 12'(rdy));
  endtask
  always @(negedge clock_in) if (arm) begin
    chk("oe_onehot", 12'($onehot0(io.Register_Control_Bus[11:6])), 12'd1);
    chk("ld_only_in_load", 12'(io.Register_Control_Bus[5:0] == 6'd0 || dut.state == LOAD), 12'd1);
    chk("done_err_excl", 12'(!(io.done && io.err)), 12'd1);
    chk("one_ready", 12'(!(io.req0_ready && io.req1_ready)), 12'd1);
  end
  initial begin
    req(0, 0, 0, 0); req(1, 0, 0, 0);
    tick; tick;
    outs("reset", 12'h000, 0, 0, 0, 2'b00);
    arm = 1'b1;
    reset_in = 1'b0;
    req(0, 1, 0, 6'b000010);
    tick; outs("t1.accept", 12'h000, 0, 0, 0, 2'b01);
    tick; req(0, 0, 5, 6'h3f); outs("t1.drive", 12'h040, 1, 0, 0, 2'b00);
    tick; outs("t1.load", 12'h042, 1, 0, 0, 2'b00);
    tick; outs("t1.turn", 12'h000, 1, 1, 0, 2'b00); chk("t1.id", 12'(io.done_id), 12'd0);
    tick; outs("t1.idle", 12'h000, 0, 0, 0, 2'b00);
    req(1, 1, 6, 6'b110000);
    tick; outs("t2.accept", 12'h000, 0, 0, 0, 2'b10);
    tick; req(1, 0, 0, 0); outs("t2.drive", 12'h000, 1, 0, 0, 2'b00);
    tick; outs("t2.load", 12'h030, 1, 0, 0, 2'b00);
    tick; outs("t2.turn", 12'h000, 1, 1, 0, 2'b00); chk("t2.id", 12'(io.done_id), 12'd1);
    tick; outs("t2.idle", 12'h000, 0, 0, 0, 2'b00);
    req(0, 1, 7, 6'b000001); req(1, 1, 1, 6'b000001);
    tick; outs("t3.accept", 12'h000, 0, 0, 0, 2'b01);
    tick; req(0, 0, 0, 0); outs("t3.err", 12'h000, 0, 0, 1, 2'b10);
    tick; req(1, 0, 0, 0); outs("t3.drive", 12'h080, 1, 0, 0, 2'b00);
    tick; outs("t3.load", 12'h081, 1, 0, 0, 2'b00);
    tick; outs("t3.turn", 12'h000, 1, 1, 0, 2'b00); chk("t3.id", 12'(io.done_id), 12'd1);
    tick; outs("t3.idle", 12'h000, 0, 0, 0, 2'b00);
    req(0, 1, 2, 6'b000000);
    tick; outs("t4.accept", 12'h000, 0, 0, 0, 2'b01);
    tick; req(0, 0, 0, 0); outs("t4.err", 12'h000, 0, 0, 1, 2'b01);
    tick; outs("t4.idle", 12'h000, 0, 0, 0, 2'b00);
    reset_in = 1'b1; req(0, 1, 0, 6'b000001); req(1, 1, 4, 6'b000010);
    tick; outs("t5.reset", 12'h000, 0, 0, 0, 2'b00);
    reset_in = 1'b0;
    tick; outs("t5.acc0", 12'h000, 0, 0, 0, 2'b01);
    tick; outs("t5.drive0", 12'h040, 1, 0, 0, 2'b00);
    tick; outs("t5.load0", 12'h041, 1, 0, 0, 2'b00);
    tick; outs("t5.turn0", 12'h000, 1, 1, 0, 2'b00); chk("t5.id0", 12'(io.done_id), 12'd0);
    tick; outs("t5.acc1", 12'h000, 0, 0, 0, 2'b10);
    tick; outs("t5.drive1", 12'h400, 1, 0, 0, 2'b00);
    tick; outs("t5.load1", 12'h402, 1, 0, 0, 2'b00);
    tick; outs("t5.turn1", 12'h000, 1, 1, 0, 2'b00); chk("t5.id1", 12'(io.done_id), 12'd1);
    tick; outs("t5.acc2", 12'h000, 0, 0, 0, 2'b01);
    tick; tick;
    tick; chk("t5.done2", 12'(io.done), 12'd1); chk("t5.id2", 12'(io.done_id), 12'd0);
    tick; outs("t5.acc3", 12'h000, 0, 0, 0, 2'b10);
    req(0, 0, 0, 0); req(1, 0, 0, 0);
    tick; outs("t6.idle", 12'h000, 0, 0, 0, 2'b00);
    req(0, 1, 2, 6'b000100);
    tick; outs("t6.accept", 12'h000, 0, 0, 0, 2'b01);
    tick; outs("t6.drive", 12'h100, 1, 0, 0, 2'b00);
    tick; outs("t6.load", 12'h104, 1, 0, 0, 2'b00);
    reset_in = 1'b1;
    tick; outs("t6.reset", 12'h000, 0, 0, 0, 2'b00);
    reset_in = 1'b0;
    tick; outs("t6.reready", 12'h000, 0, 0, 0, 2'b01);
    tick; req(0, 0, 0, 0); outs("t6.drive2", 12'h100, 1, 0, 0, 2'b00);
    tick; outs("t6.load2", 12'h104, 1, 0, 0, 2'b00);
    tick; outs("t6.turn2", 12'h000, 1, 1, 0, 2'b00); chk("t6.id", 12'(io.done_id), 12'd0);
    tick;
    arm = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/register_transfer_sequencer.md
REGISTER_TRANSFER_SEQUENCER -- requirements
Module: register_transfer_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clock_in and reset_in.
REQ-002 clock_in  input  1  system clock; all state SHALL update on posedge clock_in.
REQ-003 reset_in  input  1  synchronous active-high reset.
REQ-004 reqN_valid  input  1  (N=0,1) requester N has a transfer pending.
REQ-005 reqN_src  input  3  source code: 0=A, 1=B, 2=C, 3=P, 4=S, 5=ST, 6=EXT (another unit drives the bus), 7=illegal.
REQ-006 reqN_dst  input  6  destination load mask; bit k loads register k (A..ST order).
REQ-007 reqN_ready  output  1  accept pulse; a transfer is taken when reqN_valid and reqN_ready are both 1.
REQ-008 Register_Control_Bus  output  12  [5:0] load enables, [11:6] output enables, same order as REQ-005.
REQ-009 busy  output  1  1 whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse when a transfer completes.
REQ-011 done_id  output  1  requester index of the completed transfer; valid only with done.
REQ-012 err  output  1  one-cycle pulse when an accepted request is rejected.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The FSM SHALL have states IDLE, DRIVE, LOAD and TURN.
REQ-015 Ready SHALL be asserted only in IDLE, for at most one requester per cycle.
REQ-016 Arbitration SHALL be two-way round-robin: with both valid, the requester not granted last wins; a lone valid request always wins.
REQ-017 The round-robin pointer SHALL update only on acceptance.
REQ-018 Accept in cycle t SHALL latch src, dst and id, then move to DRIVE in t+1.
REQ-019 DRIVE: the source output-enable bit SHALL be 1 (none for EXT) and all load bits SHALL be 0.
REQ-020 LOAD (t+2): the source output-enable SHALL stay 1 and the load bits SHALL equal dst.
REQ-021 TURN (t+3): Register_Control_Bus SHALL be 0, done=1, done_id=latched id; IDLE follows in t+4.
REQ-022 Throughput SHALL be one transfer per 4 cycles.
REQ-023 At most one output-enable bit SHALL ever be 1.
REQ-024 Load bits SHALL be nonzero only in LOAD.
REQ-025 Illegal request (src=7 or dst=0): it SHALL be accepted, then in t+1 err=1, done=0, control bus 0, state IDLE, and the pointer SHALL still update.
REQ-026 A source bit that is also set in dst (self-load) SHALL be legal and SHALL run as a normal transfer.
REQ-027 Requester inputs SHALL be sampled only in the accept cycle; later changes SHALL have no effect on the transfer.

Reset
REQ-028 While reset_in is high at a posedge, the next cycle SHALL give: state IDLE, Register_Control_Bus=0, busy=0, done=0, err=0, ready=0, pointer favouring req0.
REQ-029 Reset during DRIVE, LOAD or TURN SHALL abort the transfer with no done pulse, and the request SHALL not be replayed.
REQ-030 In the first cycle after reset, ready SHALL be allowed.

Structure
REQ-031 Package cpup_reg_pkg SHALL hold:
- register index constants (A=0..ST=5, EXT=6, ILLEGAL=7);
- LD_BASE=0 and OE_BASE=6;
- the FSM state enum.
REQ-032 The arbiter SHALL be the sub-module rr_arbiter2 (inputs: valid[1:0], accept strobe; outputs: grant[1:0], pointer).
REQ-033 Code decode and FSM SHALL stay in the top module.

Verification
REQ-034 req0 src=0, dst=6'b000010 at t -> t+1 bus=0x040; t+2 bus=0x042; t+3 bus=0x000, done=1, done_id=0.
REQ-035 req0 and req1 valid from reset: accepts go 0,1,0,1 at cycles 4 apart, one transfer per 4 cycles, never two readies in one cycle.
REQ-036 req1 src=6, dst=6'b110000 -> t+1 bus=0x000; t+2 bus=0x030; t+3 done=1, done_id=1.
REQ-037 req0 src=7 or dst=0 -> t+1 err=1, done=0, bus=0; next accept goes to req1 if valid.
REQ-038 reset_in high during LOAD -> next cycle bus=0, busy=0, no done; the following req0 is accepted in the first cycle after reset.
REQ-039 Assertions SHALL run throughout: at most one output-enable bit set; load bits nonzero only in LOAD; done and err never both high.
